// File: rtl/ram_loader_pkg.sv
// ============================================================================
//  Module   : ram_loader_pkg
//  Purpose  : Shared RAM geometry and loader FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SETUP     = 3'd2,
        STROBE    = 3'd3,
        RELEASE   = 3'd4,
        FINISH    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_addr_ctr.sv
// ============================================================================
//  Module   : loader_addr_ctr
//  Purpose  : Loadable wrapping address counter plus remaining-words counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_addr_ctr #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [CNT_W-1:0] r_remaining;

    // The address wraps naturally at its width, so 15 steps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            r_remaining <= '0;
        end else if (load) begin
            addr        <= load_addr;
            r_remaining <= load_count;
        end else if (step) begin
            addr        <= addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    assign last = (r_remaining == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/ram_loader.sv
// ============================================================================
//  Module   : ram_loader
//  Purpose  : Streams bytes into the program RAM through its programming port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_loader #(
    parameter int ADDR_W = ram_loader_pkg::ADDR_W,
    parameter int DATA_W = ram_loader_pkg::DATA_W,
    parameter int DEPTH  = ram_loader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prg_mode,
    output logic [ADDR_W-1:0] prg_addr,
    output logic [DATA_W-1:0] prg_data,
    output logic              prg_wr_en,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    import ram_loader_pkg::*;

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W:0]   w_eff_len;
    logic              w_load;
    logic              w_step;
    logic              w_last;

    // Zero means a full-RAM load; oversize requests saturate at the RAM depth.
    assign w_eff_len = ((length == '0) || (length > C_DEPTH)) ? C_DEPTH : length;

    assign w_load = (r_state == IDLE) && start && !abort;
    assign w_step = (r_state == RELEASE) && !abort;

    loader_addr_ctr #(
        .ADDR_W (ADDR_W),
        .CNT_W  (ADDR_W + 1)
    ) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_addr  (start_addr),
        .load_count (w_eff_len),
        .step       (w_step),
        .addr       (prg_addr),
        .last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            in_ready      <= 1'b0;
            prg_mode      <= 1'b0;
            prg_data      <= '0;
            prg_wr_en     <= 1'b0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                // A strobe cut short here is never counted as written.
                r_state   <= IDLE;
                in_ready  <= 1'b0;
                prg_wr_en <= 1'b0;
                prg_mode  <= 1'b0;
                cpu_hold  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !abort) begin
                            r_state       <= WAIT_BYTE;
                            words_written <= '0;
                            prg_mode      <= 1'b1;
                            cpu_hold      <= 1'b1;
                            busy          <= 1'b1;
                            in_ready      <= 1'b1;
                        end
                    end
                    WAIT_BYTE: begin
                        if (in_valid) begin
                            prg_data <= in_data;
                            in_ready <= 1'b0;
                            r_state  <= SETUP;
                        end
                    end
                    SETUP: begin
                        prg_wr_en <= 1'b1;
                        r_state   <= STROBE;
                    end
                    STROBE: begin
                        prg_wr_en <= 1'b0;
                        r_state   <= RELEASE;
                    end
                    RELEASE: begin
                        words_written <= words_written + 1'b1;
                        if (w_last) begin
                            done    <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            in_ready <= 1'b1;
                            r_state  <= WAIT_BYTE;
                        end
                    end
                    FINISH: begin
                        prg_mode <= 1'b0;
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                        r_state  <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// ============================================================================
//  Module   : tb_ram_loader
//  Purpose  : Directed, table-driven self-checking bench for ram_loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       prg_mode;
    logic [3:0] prg_addr;
    logic [7:0] prg_data;
    logic       prg_wr_en;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [4:0] words_written;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .length        (length),
        .abort         (abort),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .prg_mode      (prg_mode),
        .prg_addr      (prg_addr),
        .prg_data      (prg_data),
        .prg_wr_en     (prg_wr_en),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    typedef struct {
        logic [3:0] sa;
        logic [4:0] len;
        logic [7:0] d0;
        logic [7:0] step;
        int         gapmax;
        int         exp_n;
    } vec_t;

    vec_t vecs [6];

    logic [3:0] wq_addr [$];
    logic [7:0] wq_data [$];
    int         acc_cyc [$];
    logic [7:0] ram [16];
    int         done_seen;
    logic [3:0] prev_addr;
    logic [7:0] prev_data;

    int         idx, gap, gapmax_g, nsend, cyc;
    logic       pend;
    logic [7:0] d0_g, step_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM model and strobe-window stability monitor.
    always @(negedge clk) begin
        if (prg_wr_en) begin
            check("strobe_addr_stable", 32'(prg_addr), 32'(prev_addr));
            check("strobe_data_stable", 32'(prg_data), 32'(prev_data));
            check("mode_during_strobe", 32'(prg_mode), 32'd1);
            wq_addr.push_back(prg_addr);
            wq_data.push_back(prg_data);
            ram[prg_addr] = prg_data;
        end
        if (done) done_seen++;
        prev_addr = prg_addr;
        prev_data = prg_data;
    end

    task automatic stream_cycle();
        @(negedge clk);
        cyc++;
        if (pend) begin
            acc_cyc.push_back(cyc);
            idx++;
            in_valid = 1'b0;
            gap = (gapmax_g == 0) ? 0 : ((idx * 2 + 3) % (gapmax_g + 1));
        end
        if (!in_valid && idx < nsend) begin
            if (gap == 0) begin
                in_valid = 1'b1;
                in_data  = 8'(int'(d0_g) + int'(step_g) * idx);
            end else begin
                gap--;
            end
        end
        pend = in_valid && in_ready;
    endtask

    task automatic start_load(input logic [3:0] sa, input logic [4:0] len, input logic [7:0] d0,
                              input logic [7:0] st, input int gm, input int ns);
        @(negedge clk);
        start = 1'b1; start_addr = sa; length = len;
        idx = 0; gap = 0; pend = 1'b0; in_valid = 1'b0; cyc = 0;
        d0_g = d0; step_g = st; gapmax_g = gm; nsend = ns;
        wq_addr.delete(); wq_data.delete(); acc_cyc.delete();
        done_seen = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        int  n;
        bit  fin;
        logic [3:0] a;
        logic [7:0] d;
        start_load(v.sa, v.len, v.d0, v.step, v.gapmax, v.exp_n + 2);
        n = 0; fin = 0;
        while (!fin && n < 600) begin
            stream_cycle();
            n++;
            if (done) fin = 1;
        end
        check("done_timeout", 32'(fin), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("done_pulses", 32'(done_seen), 32'd1);
        check("write_count", 32'(wq_addr.size()), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < wq_addr.size(); i++) begin
            a = 4'(int'(v.sa) + i);
            d = 8'(int'(v.d0) + int'(v.step) * i);
            check("write_addr", 32'(wq_addr[i]), 32'(a));
            check("write_data", 32'(wq_data[i]), 32'(d));
            check("ram_readback", 32'(ram[a]), 32'(d));
        end
        check("words_written", 32'(words_written), 32'(v.exp_n));
        check("idle_after_load", {29'd0, busy, prg_mode, cpu_hold}, 32'd0);
        if (v.gapmax == 0) begin
            for (int i = 1; i < acc_cyc.size(); i++)
                check("in_ready_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
        end
    endtask

    initial begin
        int  n;
        int  strobes;
        bit  fin;

        vecs[0] = '{sa: 4'd0,  len: 5'd0,  d0: 8'h00, step: 8'h01, gapmax: 0, exp_n: 16};
        vecs[1] = '{sa: 4'd14, len: 5'd3,  d0: 8'hA1, step: 8'h11, gapmax: 0, exp_n: 3};
        vecs[2] = '{sa: 4'd3,  len: 5'd4,  d0: 8'h40, step: 8'h03, gapmax: 5, exp_n: 4};
        vecs[3] = '{sa: 4'd5,  len: 5'd20, d0: 8'h80, step: 8'h01, gapmax: 0, exp_n: 16};
        vecs[4] = '{sa: 4'd15, len: 5'd1,  d0: 8'hE7, step: 8'h00, gapmax: 2, exp_n: 1};
        vecs[5] = '{sa: 4'd9,  len: 5'd16, d0: 8'hF0, step: 8'h07, gapmax: 1, exp_n: 16};

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; start_addr = 4'd0; length = 5'd0;
        idx = 0; gap = 0; pend = 1'b0; cyc = 0; nsend = 0;
        gapmax_g = 0; d0_g = 8'h00; step_g = 8'h00; done_seen = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {9'd0, in_ready, prg_mode, prg_addr, prg_data, prg_wr_en,
                                cpu_hold, busy, done, words_written}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) run_vector(vecs[v]);

        // Abort while the third strobe is high.
        start_load(4'd0, 5'd8, 8'h10, 8'h01, 0, 10);
        n = 0; strobes = 0; fin = 0;
        while (!fin && n < 300) begin
            stream_cycle();
            n++;
            if (prg_wr_en) begin
                strobes++;
                if (strobes == 3) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    in_valid = 1'b0;
                    fin = 1;
                end
            end
        end
        check("abort_reached", 32'(fin), 32'd1);
        check("abort_outputs", {27'd0, prg_wr_en, prg_mode, busy, cpu_hold, in_ready}, 32'd0);
        check("abort_words_written", 32'(words_written), 32'd2);
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; start_addr = 4'd6; length = 5'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {29'd0, busy, prg_mode, in_ready}, 32'd0);

        // Start pulsed during WAIT_BYTE is ignored; then reset during SETUP.
        start_load(4'd2, 5'd2, 8'h55, 8'h01, 0, 0);
        check("wait_in_ready", 32'(in_ready), 32'd1);
        check("wait_addr", 32'(prg_addr), 32'd2);
        start = 1'b1; start_addr = 4'd9; length = 5'd5;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start", {19'd0, in_ready, busy, prg_mode, prg_addr, words_written},
              {19'd0, 1'b1, 1'b1, 1'b1, 4'd2, 5'd0});
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        check("setup_state", {23'd0, prg_wr_en, prg_data}, {23'd0, 1'b0, 8'h77});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_load", {9'd0, in_ready, prg_mode, prg_addr, prg_data, prg_wr_en,
                                 cpu_hold, busy, done, words_written}, 32'd0);
        run_vector('{sa: 4'd7, len: 5'd2, d0: 8'h3C, step: 8'h05, gapmax: 0, exp_n: 2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
